// File: rtl/hazard_sb_pkg.sv
// Shared types and default sizing for the parametrised hazard unit.
//   fwd_sel_e : per-operand forwarding select driven onto ForwardE
//   *_DEF     : default register-address width, source count and counter width
package hazard_sb_pkg;

    localparam int unsigned AW_DEF   = 5;
    localparam int unsigned NSRC_DEF = 2;
    localparam int unsigned CW_DEF   = 32;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/hazard_sb_if.sv
// Pipeline-to-hazard-unit bundle.
//   master : pipeline side, drives stage info and consumes stall/flush/forward
//   slave  : hazard unit side
interface hazard_sb_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned NSRC = 2,
    parameter int unsigned CW   = 32
);

    logic [NSRC*AW-1:0] RsD;
    logic [AW-1:0]      RdD;
    logic               RegWriteD;
    logic               LongD;
    logic [NSRC*AW-1:0] RsE;
    logic [AW-1:0]      RdE;
    logic [AW-1:0]      RdM;
    logic [AW-1:0]      RdW;
    logic               LoadE;
    logic               LoadM;
    logic               RegWriteM;
    logic               RegWriteW;
    logic               LongIssueE;
    logic               LongDone;
    logic [AW-1:0]      LongDoneRd;
    logic               mispredict;
    logic               PCstall;
    logic               waitM;

    logic [2*NSRC-1:0]  ForwardE;
    logic               StallF;
    logic               StallD;
    logic               StallE;
    logic               StallM;
    logic               FlushD;
    logic               FlushE;
    logic               LongBusy;
    logic [CW-1:0]      StallCycles;

    modport master (
        output RsD, RdD, RegWriteD, LongD, RsE, RdE, RdM, RdW,
               LoadE, LoadM, RegWriteM, RegWriteW, LongIssueE,
               LongDone, LongDoneRd, mispredict, PCstall, waitM,
        input  ForwardE, StallF, StallD, StallE, StallM, FlushD, FlushE,
               LongBusy, StallCycles
    );

    modport slave (
        input  RsD, RdD, RegWriteD, LongD, RsE, RdE, RdM, RdW,
               LoadE, LoadM, RegWriteM, RegWriteW, LongIssueE,
               LongDone, LongDoneRd, mispredict, PCstall, waitM,
        output ForwardE, StallF, StallD, StallE, StallM, FlushD, FlushE,
               LongBusy, StallCycles
    );

endinterface

// File: rtl/hazard_sb_scoreboard.sv
// Per-register pending-write tracker for out-of-order long ops.
//   issue/issue_rd : long op leaves E toward the long unit
//   done/done_rd   : long unit completion
//   sb             : one pending bit per register (bit 0 tied low)
//   full           : outstanding count at MAX_LONG
//   busy           : at least one long op outstanding
module hazard_sb_scoreboard #(
    parameter int unsigned AW       = 5,
    parameter int unsigned MAX_LONG = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue,
    input  logic [AW-1:0]        issue_rd,
    input  logic                 done,
    input  logic [AW-1:0]        done_rd,
    output logic [(1<<AW)-1:0]   sb,
    output logic                 full,
    output logic                 busy
);

    localparam int unsigned NREG = 1 << AW;
    localparam int unsigned CNTW = $clog2(MAX_LONG + 1);

    logic [NREG-1:0] sb_nxt;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;

    // Clear on completion first so a same-cycle issue to that register wins.
    always_comb begin
        sb_nxt = sb;
        if (done) begin
            sb_nxt[done_rd] = 1'b0;
        end
        if (issue && (issue_rd != '0)) begin
            sb_nxt[issue_rd] = 1'b1;
        end
        sb_nxt[0] = 1'b0;
    end

    // Issue and completion together leave the count unchanged; an orphan
    // completion at zero holds the count instead of wrapping.
    always_comb begin
        cnt_nxt = cnt;
        if (issue && !done) begin
            cnt_nxt = cnt + CNTW'(1);
        end else if (!issue && done && (cnt != '0)) begin
            cnt_nxt = cnt - CNTW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sb  <= '0;
            cnt <= '0;
        end else begin
            assert (!(done && !issue && (cnt == '0)));
            sb  <= sb_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign full = (cnt == CNTW'(MAX_LONG));
    assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit for the five-stage RV32 core: M/W forwarding, load-use and
// scoreboard stalls, mispredict flush, memory-wait stall, stall perf counter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : hazard_sb_if slave (decode/execute/memory info in,
//                forward selects, stalls, flushes, LongBusy, StallCycles out)
module hazard_sb
    import hazard_sb_pkg::*;
#(
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned NSRC     = NSRC_DEF,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned MAX_LONG = 2,
    parameter int unsigned CW       = CW_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    hazard_sb_if.slave  bus
);

    localparam int unsigned NREG = 1 << AW;

    logic [NSRC-1:0][AW-1:0] rs_d;
    logic [NSRC-1:0][AW-1:0] rs_e;
    logic [NSRC-1:0][1:0]    fwd;
    logic                    ld_stall;
    logic                    sb_stall;
    logic                    hz;
    logic                    stall_d;
    logic                    flush_e;
    logic                    issue;
    logic [NREG-1:0]         sb_vec;
    logic                    sb_full;
    logic                    long_busy;
    logic [CW-1:0]           stall_cnt;

    assign rs_d = bus.RsD;
    assign rs_e = bus.RsE;

    // Forwarding: M has priority over W; x0 always reads the regfile.
    always_comb begin
        fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (rs_e[i] == '0) begin
                fwd[i] = 2'(FWD_RF);
            end else if ((rs_e[i] == bus.RdM) && bus.RegWriteM) begin
                fwd[i] = 2'(FWD_M);
            end else if ((rs_e[i] == bus.RdW) && bus.RegWriteW) begin
                fwd[i] = 2'(FWD_W);
            end else begin
                fwd[i] = 2'(FWD_RF);
            end
        end
    end

    // Load-use: with LOAD_LAT==2 a load still in M also blocks decode.
    always_comb begin
        ld_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.LoadE && (bus.RdE != '0) && (rs_d[i] == bus.RdE)) begin
                ld_stall = 1'b1;
            end
            if ((LOAD_LAT == 2) && bus.LoadM && (bus.RdM != '0) &&
                (rs_d[i] == bus.RdM)) begin
                ld_stall = 1'b1;
            end
        end
    end

    // Scoreboard: RAW on any source, WAW on destination, structural on full.
    always_comb begin
        sb_stall = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if ((rs_d[i] != '0) && sb_vec[rs_d[i]]) begin
                sb_stall = 1'b1;
            end
        end
        if (bus.RegWriteD && (bus.RdD != '0) && sb_vec[bus.RdD]) begin
            sb_stall = 1'b1;
        end
        if (bus.LongD && sb_full) begin
            sb_stall = 1'b1;
        end
    end

    assign hz      = ld_stall | sb_stall;
    assign stall_d = hz | bus.waitM;
    // A held E stage must keep its instruction, so the bubble waits for waitM.
    assign flush_e = bus.mispredict | (hz & ~bus.waitM);
    assign issue   = bus.LongIssueE & ~bus.waitM & ~flush_e;

    hazard_sb_scoreboard #(
        .AW       (AW),
        .MAX_LONG (MAX_LONG)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue    (issue),
        .issue_rd (bus.RdE),
        .done     (bus.LongDone),
        .done_rd  (bus.LongDoneRd),
        .sb       (sb_vec),
        .full     (sb_full),
        .busy     (long_busy)
    );

    // Reset forces a bubble: no stalls, both flushes high, regfile operands.
    always_comb begin
        bus.ForwardE = '0;
        bus.StallF   = 1'b0;
        bus.StallD   = 1'b0;
        bus.StallE   = 1'b0;
        bus.StallM   = 1'b0;
        bus.FlushD   = 1'b1;
        bus.FlushE   = 1'b1;
        if (rst_n) begin
            bus.ForwardE = fwd;
            bus.StallF   = hz | bus.PCstall | bus.waitM;
            bus.StallD   = stall_d;
            bus.StallE   = bus.waitM;
            bus.StallM   = bus.waitM;
            bus.FlushD   = bus.mispredict;
            bus.FlushE   = flush_e;
        end
    end

    // Saturating count of decode-stall cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall_d && (stall_cnt != {CW{1'b1}})) begin
            stall_cnt <= stall_cnt + CW'(1);
        end
    end

    assign bus.LongBusy    = long_busy;
    assign bus.StallCycles = stall_cnt;

endmodule

// File: tb/tb_hazard_sb.sv
// Directed bench: two hazard_sb instances fed identical stimulus.
//   dut_a : LOAD_LAT=1, CW=32   dut_b : LOAD_LAT=2, CW=4
module tb_hazard_sb;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [9:0] RsD, RsE;
    logic [4:0] RdD, RdE, RdM, RdW, LongDoneRd;
    logic RegWriteD, LongD, LoadE, LoadM, RegWriteM, RegWriteW;
    logic LongIssueE, LongDone, mispredict, PCstall, waitM;

    int vectors = 0;
    int errs    = 0;

    hazard_sb_if #(.AW(5), .NSRC(2), .CW(32)) ifa ();
    hazard_sb_if #(.AW(5), .NSRC(2), .CW(4))  ifb ();

    assign ifa.RsD = RsD;               assign ifb.RsD = RsD;
    assign ifa.RdD = RdD;               assign ifb.RdD = RdD;
    assign ifa.RegWriteD = RegWriteD;   assign ifb.RegWriteD = RegWriteD;
    assign ifa.LongD = LongD;           assign ifb.LongD = LongD;
    assign ifa.RsE = RsE;               assign ifb.RsE = RsE;
    assign ifa.RdE = RdE;               assign ifb.RdE = RdE;
    assign ifa.RdM = RdM;               assign ifb.RdM = RdM;
    assign ifa.RdW = RdW;               assign ifb.RdW = RdW;
    assign ifa.LoadE = LoadE;           assign ifb.LoadE = LoadE;
    assign ifa.LoadM = LoadM;           assign ifb.LoadM = LoadM;
    assign ifa.RegWriteM = RegWriteM;   assign ifb.RegWriteM = RegWriteM;
    assign ifa.RegWriteW = RegWriteW;   assign ifb.RegWriteW = RegWriteW;
    assign ifa.LongIssueE = LongIssueE; assign ifb.LongIssueE = LongIssueE;
    assign ifa.LongDone = LongDone;     assign ifb.LongDone = LongDone;
    assign ifa.LongDoneRd = LongDoneRd; assign ifb.LongDoneRd = LongDoneRd;
    assign ifa.mispredict = mispredict; assign ifb.mispredict = mispredict;
    assign ifa.PCstall = PCstall;       assign ifb.PCstall = PCstall;
    assign ifa.waitM = waitM;           assign ifb.waitM = waitM;

    hazard_sb #(.AW(5), .NSRC(2), .LOAD_LAT(1), .MAX_LONG(2), .CW(32)) dut_a (
        .clk (clk), .rst_n (rst_n), .bus (ifa)
    );
    hazard_sb #(.AW(5), .NSRC(2), .LOAD_LAT(2), .MAX_LONG(2), .CW(4)) dut_b (
        .clk (clk), .rst_n (rst_n), .bus (ifb)
    );

    function automatic logic [9:0] rs2(input logic [4:0] r1, input logic [4:0] r0);
        return {r1, r0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_in();
        RsD = '0; RsE = '0; RdD = '0; RdE = '0; RdM = '0; RdW = '0; LongDoneRd = '0;
        RegWriteD = 0; LongD = 0; LoadE = 0; LoadM = 0; RegWriteM = 0; RegWriteW = 0;
        LongIssueE = 0; LongDone = 0; mispredict = 0; PCstall = 0; waitM = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        // reset with hazards present on the inputs
        clear_in();
        rst_n = 0;
        LoadE = 1; RdE = 5'd7; RsD = rs2(5'd7, 5'd0);
        RsE = rs2(5'd0, 5'd5); RdM = 5'd5; RegWriteM = 1;
        settle();
        chk("rst_stalld", 32'(ifa.StallD), 32'd0);
        chk("rst_stallf", 32'(ifa.StallF), 32'd0);
        chk("rst_flushd", 32'(ifa.FlushD), 32'd1);
        chk("rst_flushe", 32'(ifa.FlushE), 32'd1);
        chk("rst_fwd",    32'(ifa.ForwardE), 32'd0);
        tick(); tick();
        clear_in();
        rst_n = 1;
        settle();
        chk("rst_cnt_a", ifa.StallCycles, 32'd0);
        chk("rst_cnt_b", 32'(ifb.StallCycles), 32'd0);
        chk("rst_busy",  32'(ifa.LongBusy), 32'd0);

        // forwarding priority
        RsE = rs2(5'd0, 5'd5); RdM = 5'd5; RegWriteM = 1; RdW = 5'd5; RegWriteW = 1;
        settle(); chk("fwd_m", 32'(ifa.ForwardE), 32'b0010);
        RegWriteM = 0;
        settle(); chk("fwd_w", 32'(ifa.ForwardE), 32'b0001);
        RegWriteM = 1; RsE = rs2(5'd5, 5'd0);
        settle(); chk("fwd_op1_m", 32'(ifa.ForwardE), 32'b1000);
        RsE = rs2(5'd5, 5'd5); RdM = 5'd6;
        settle(); chk("fwd_both_w", 32'(ifa.ForwardE), 32'b0101);
        RsE = '0;
        settle(); chk("fwd_rf", 32'(ifa.ForwardE), 32'b0000);
        clear_in();

        // load-use: a stalls 1 cycle, b stalls 2
        LoadE = 1; RdE = 5'd7; RsD = rs2(5'd7, 5'd0);
        settle();
        chk("ld_a_stallf", 32'(ifa.StallF), 32'd1);
        chk("ld_a_stalld", 32'(ifa.StallD), 32'd1);
        chk("ld_a_flushe", 32'(ifa.FlushE), 32'd1);
        chk("ld_a_stalle", 32'(ifa.StallE), 32'd0);
        chk("ld_b_stalld", 32'(ifb.StallD), 32'd1);
        tick();
        LoadE = 0; RdE = '0; LoadM = 1; RdM = 5'd7; RegWriteM = 1;
        settle();
        chk("ld2_a_stalld", 32'(ifa.StallD), 32'd0);
        chk("ld2_a_flushe", 32'(ifa.FlushE), 32'd0);
        chk("ld2_b_stalld", 32'(ifb.StallD), 32'd1);
        chk("ld2_b_flushe", 32'(ifb.FlushE), 32'd1);
        tick();
        LoadM = 0; RdM = '0; RegWriteM = 0;
        settle();
        chk("ld3_b_stalld", 32'(ifb.StallD), 32'd0);
        chk("ld_cnt_a", ifa.StallCycles, 32'd1);
        chk("ld_cnt_b", 32'(ifb.StallCycles), 32'd2);
        clear_in();

        // long RAW on x9
        LongIssueE = 1; RdE = 5'd9;
        settle(); chk("raw_busy0", 32'(ifa.LongBusy), 32'd0);
        tick();
        clear_in(); RsD = rs2(5'd0, 5'd9);
        settle();
        chk("raw_busy1", 32'(ifa.LongBusy), 32'd1);
        chk("raw_stalld1", 32'(ifa.StallD), 32'd1);
        chk("raw_flushe1", 32'(ifa.FlushE), 32'd1);
        tick();
        settle(); chk("raw_stalld2", 32'(ifa.StallD), 32'd1);
        tick();
        LongDone = 1; LongDoneRd = 5'd9;
        settle(); chk("raw_stalld_done", 32'(ifa.StallD), 32'd1);
        tick();
        LongDone = 0;
        settle();
        chk("raw_release", 32'(ifa.StallD), 32'd0);
        chk("raw_busy_end", 32'(ifa.LongBusy), 32'd0);
        chk("raw_cnt_a", ifa.StallCycles, 32'd4);
        chk("raw_cnt_b", 32'(ifb.StallCycles), 32'd5);
        clear_in();

        // structural: two outstanding (x3, x4), then a long op in decode
        LongIssueE = 1; RdE = 5'd3; tick();
        RdE = 5'd4; tick();
        clear_in(); LongD = 1; RegWriteD = 1; RdD = 5'd5;
        settle(); chk("struct_stall", 32'(ifa.StallD), 32'd1);
        tick();
        LongDone = 1; LongDoneRd = 5'd4;
        settle(); chk("struct_stall_done", 32'(ifa.StallD), 32'd1);
        tick();
        LongDone = 0;
        settle(); chk("struct_release", 32'(ifa.StallD), 32'd0);
        LongD = 0; RdD = 5'd3;
        settle(); chk("waw_stall", 32'(ifa.StallD), 32'd1);
        clear_in();

        // same-cycle issue and completion on x3: set wins, count unchanged
        LongIssueE = 1; RdE = 5'd3; LongDone = 1; LongDoneRd = 5'd3;
        tick();
        clear_in(); RsD = rs2(5'd3, 5'd0);
        settle();
        chk("same_sb3", 32'(ifa.StallD), 32'd1);
        chk("same_busy", 32'(ifa.LongBusy), 32'd1);
        RsD = '0; LongD = 1;
        settle(); chk("same_cnt1", 32'(ifa.StallD), 32'd0);
        mispredict = 1; LongD = 0; RsD = rs2(5'd0, 5'd3);
        settle();
        chk("mp_flushd", 32'(ifa.FlushD), 32'd1);
        chk("mp_flushe", 32'(ifa.FlushE), 32'd1);
        chk("mp_stalld", 32'(ifa.StallD), 32'd1);
        clear_in();

        // waitM during a load-use hazard
        LoadE = 1; RdE = 5'd7; RsD = rs2(5'd7, 5'd0); waitM = 1;
        settle();
        chk("wait_stalle", 32'(ifa.StallE), 32'd1);
        chk("wait_stallm", 32'(ifa.StallM), 32'd1);
        chk("wait_flushe", 32'(ifa.FlushE), 32'd0);
        chk("wait_stallf", 32'(ifa.StallF), 32'd1);
        tick();
        waitM = 0;
        settle();
        chk("wait_rel_flushe", 32'(ifa.FlushE), 32'd1);
        chk("wait_rel_stalle", 32'(ifa.StallE), 32'd0);
        tick();
        clear_in();
        settle();
        chk("wait_cnt_a", ifa.StallCycles, 32'd8);
        chk("wait_cnt_b", 32'(ifb.StallCycles), 32'd9);

        // reset mid-operation with two long ops outstanding (x3, x8)
        LongIssueE = 1; RdE = 5'd8; tick();
        clear_in();
        settle(); chk("pre_rst_busy", 32'(ifa.LongBusy), 32'd1);
        rst_n = 0; tick();
        rst_n = 1;
        settle();
        chk("mid_rst_busy", 32'(ifa.LongBusy), 32'd0);
        chk("mid_rst_cnt_a", ifa.StallCycles, 32'd0);
        chk("mid_rst_cnt_b", 32'(ifb.StallCycles), 32'd0);
        RsD = rs2(5'd8, 5'd3);
        settle(); chk("mid_rst_sb", 32'(ifa.StallD), 32'd0);
        RsD = '0; LongD = 1;
        settle(); chk("mid_rst_full", 32'(ifa.StallD), 32'd0);
        clear_in();

        // saturation of the 4-bit counter
        LoadE = 1; RdE = 5'd7; RsD = rs2(5'd7, 5'd0);
        for (int i = 0; i < 17; i++) tick();
        settle();
        chk("sat_cnt_a", ifa.StallCycles, 32'd17);
        chk("sat_cnt_b", 32'(ifb.StallCycles), 32'd15);
        tick();
        settle();
        chk("sat_hold_a", ifa.StallCycles, 32'd18);
        chk("sat_hold_b", 32'(ifb.StallCycles), 32'd15);
        clear_in();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
